// File: rtl/falling_edge_generator.sv
// Falling-edge line driver: on trig, emits N low pulses of L cycles, each followed
// by H high recovery cycles, then flags done for one cycle. Line idles high.
module falling_edge_generator #(
  parameter int CNT_W = 8,
  parameter int NP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NP_W-1:0]  n_pulses,
  output logic             line_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
  localparam logic [NP_W-1:0]  LP_NP_ONE  = NP_W'(1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_phase, w_phase_next;
  logic [NP_W-1:0]  r_remaining, w_remaining_next;
  logic [CNT_W-1:0] r_low_m1, w_low_m1_next;
  logic [CNT_W-1:0] r_high_m1, w_high_m1_next;
  logic             r_done, w_done_next;

  // Zero lengths/counts clamp to 1, so the reload value L-1 / H-1 is 0 for both 0 and 1.
  logic [CNT_W-1:0] w_low_m1_in, w_high_m1_in;
  logic [NP_W-1:0]  w_n_in;
  assign w_low_m1_in  = (low_len  == '0) ? '0 : low_len  - LP_CNT_ONE;
  assign w_high_m1_in = (high_len == '0) ? '0 : high_len - LP_CNT_ONE;
  assign w_n_in       = (n_pulses == '0) ? LP_NP_ONE : n_pulses;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_remaining_next = r_remaining;
    w_low_m1_next    = r_low_m1;
    w_high_m1_next   = r_high_m1;
    w_done_next      = 1'b0;

    case (r_state)
      IDLE: begin
        if (trig) begin
          w_low_m1_next    = w_low_m1_in;
          w_high_m1_next   = w_high_m1_in;
          w_phase_next     = w_low_m1_in;
          w_remaining_next = w_n_in;
          w_state_next     = LOW;
        end
      end
      LOW: begin
        if (r_phase == '0) begin
          w_phase_next = r_high_m1;
          w_state_next = HIGH;
        end else begin
          w_phase_next = r_phase - LP_CNT_ONE;
        end
      end
      HIGH: begin
        if (r_phase != '0) begin
          w_phase_next = r_phase - LP_CNT_ONE;
        end else if (r_remaining == LP_NP_ONE) begin
          w_remaining_next = '0;
          w_state_next     = IDLE;
          w_done_next      = 1'b1;
        end else begin
          w_remaining_next = r_remaining - LP_NP_ONE;
          w_phase_next     = r_low_m1;
          w_state_next     = LOW;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_remaining <= '0;
      r_low_m1    <= '0;
      r_high_m1   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_remaining <= w_remaining_next;
      r_low_m1    <= w_low_m1_next;
      r_high_m1   <= w_high_m1_next;
      r_done      <= w_done_next;
    end
  end

  assign line_out = (r_state != LOW);
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

endmodule

// File: doc/falling_edge_generator.md
Name: falling_edge_generator

Overview:
- Transmit side of the falling-edge signalling line. On a one-cycle trigger it drives an idle-high line low for a programmable number of cycles, then high for a programmable recovery time, repeating for a programmable number of pulses.
- It produces the edges that the team's falling-edge detector block consumes, at the other end of the same line.
- It provides busy/done status for a controlling FSM.

Parameters:
- CNT_W, 8, width of the low_len and high_len fields and of the internal phase counter.
- NP_W, 4, width of the n_pulses field and of the remaining-pulse counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- trig  input  1  start request, sampled on the rising edge of clk.
- low_len  input  CNT_W  cycles line_out stays low per pulse; 0 is treated as 1.
- high_len  input  CNT_W  recovery cycles line_out stays high after each low phase; 0 is treated as 1.
- n_pulses  input  NP_W  number of low pulses per burst; 0 is treated as 1.
- line_out  output  1  generated line; idles high.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: state=IDLE, line_out=1, busy=0, done=0, counters=0. Reset takes effect from the cycle after rst is sampled high.
- Reset mid-burst: the burst aborts, line_out returns to 1, and no done pulse is issued.
- States: IDLE, LOW, HIGH.
- Outputs are Moore-decoded from registered state:
  - line_out=0 only in LOW.
  - busy=1 in LOW and HIGH.
  - done is a registered flag.
- IDLE, trig=1:
  - Latch L=max(low_len,1), H=max(high_len,1), N=max(n_pulses,1).
  - Load phase counter with L-1 and remaining with N.
  - Go to LOW.
- Any state other than IDLE: trig is ignored. No queuing, and latched values do not change mid-burst.
- LOW:
  - If phase counter==0: load H-1 and go to HIGH.
  - Otherwise decrement.
- HIGH, phase counter==0:
  - If remaining==1: go to IDLE and set done=1 for exactly the next cycle.
  - Otherwise decrement remaining, load L-1 and go to LOW.
- HIGH, phase counter!=0: decrement.
- Timing (cycle k = first cycle after the edge that sampled trig=1):
  - line_out=0 in cycles k+p(L+H) .. k+p(L+H)+L-1, for p=0..N-1.
  - Otherwise line_out=1.
  - busy=1 in cycles k .. k+N(L+H)-1.
  - done=1 in cycle k+N(L+H) only.
- Latency: trig to first falling edge is 1 cycle.
- The final recovery phase always completes before done. This guarantees line_out has been high for ≥H cycles after the last low phase.
- Back-to-back bursts: trig=1 in the done cycle (state IDLE) is accepted. line_out goes low the following cycle, so the gap since the last low phase is H+1 cycles.
- Maximum values: L=H=2^CNT_W-1 and N=2^NP_W-1 must work. Counters never wrap; they only decrement from a loaded value to 0.
- Inputs low_len, high_len and n_pulses are don't-care except in the cycle trig is accepted.
- done and busy are never both 1.

Test Plan:
- Reset, then idle 10 cycles -> line_out=1, busy=0, done=0 throughout. trig=0 produces no activity.
- low_len=3, high_len=2, n_pulses=1, trig at cycle 0 -> line_out low in cycles 1-3 and high in 4-5, busy in 1-5, done in cycle 6 only.
- low_len=2, high_len=1, n_pulses=4 -> exactly 4 falling edges, at cycles 1, 4, 7, 10; done at cycle 13. The falling-edge detector block on line_out emits exactly 4 pulses.
- low_len=0, high_len=0, n_pulses=0 -> clamped to 1/1/1: line_out low in cycle 1 only, done in cycle 3.
- trig held high continuously, low_len=2, high_len=2, n_pulses=1 -> new burst accepted in each done cycle; later triggers during busy are ignored; bursts repeat every 5 cycles.
- rst asserted in the 2nd low cycle of low_len=5 -> line_out=1 and busy=0 from the next cycle, no done pulse; a subsequent trig starts a normal burst.
